// File: rtl/simple_xor_gate_if.sv
// Operand/result bundle for simple_xor_gate: a/b in, XOR result with parity and popcount out.
// Latency: none (wires only); the DUT registers the results one cycle after in_valid.
// Backpressure: none; a source may present a new operand pair every cycle.
//
// Signals:
//   in_valid, a, b                    : driven by the master (operand source)
//   f, f_valid, parity, diff_cnt      : driven by the slave (simple_xor_gate)
//   mismatch_cnt                      : slave output, present only with SIMPLE_XOR_MISMATCH_CNT_EN
interface simple_xor_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  // popcount range is 0..WIDTH; clog2(WIDTH+1) is never below 1 for WIDTH >= 1
  localparam int DW = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("simple_xor_gate_if: WIDTH out of range 1..64");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("simple_xor_gate_if: CNT_W out of range 1..32");
  end

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] f;
  logic             f_valid;
  logic             parity;
  logic [DW-1:0]    diff_cnt;
`ifdef SIMPLE_XOR_MISMATCH_CNT_EN
  logic [CNT_W-1:0] mismatch_cnt;
`endif

  modport master (
    output in_valid, a, b,
`ifdef SIMPLE_XOR_MISMATCH_CNT_EN
    input  mismatch_cnt,
`endif
    input  f, f_valid, parity, diff_cnt
  );

  modport slave (
    input  in_valid, a, b,
`ifdef SIMPLE_XOR_MISMATCH_CNT_EN
    output mismatch_cnt,
`endif
    output f, f_valid, parity, diff_cnt
  );
endinterface

// File: rtl/simple_xor_gate.sv
// Registered bitwise XOR of two operands with parity and popcount of the result.
// Latency: 1 cycle from in_valid to f_valid; results hold while in_valid is low.
// Backpressure: none; accepts one operand pair every cycle in_valid is high.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every output immediately
//   bus    : simple_xor_gate_if.slave (in_valid/a/b in; f/f_valid/parity/diff_cnt out)
// Optional: define SIMPLE_XOR_MISMATCH_CNT_EN to add bus.mismatch_cnt, a saturating
//   count of valid cycles where a != b.
module simple_xor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  simple_xor_gate_if.slave   bus
);
  localparam int DW = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("simple_xor_gate: WIDTH out of range 1..64");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("simple_xor_gate: CNT_W out of range 1..32");
  end

  logic [WIDTH-1:0] w_xor;
  logic             w_par;
  logic [DW-1:0]    w_pop;

  logic [WIDTH-1:0] r_f;
  logic             r_vld;
  logic             r_par;
  logic [DW-1:0]    r_pop;

  assign w_xor = bus.a ^ bus.b;
  assign w_par = ^w_xor;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + DW'(w_xor[i]);
    end
  end

  // Data registers load only on valid cycles, so a/b (including X) are
  // ignored whenever in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f   <= '0;
      r_vld <= 1'b0;
      r_par <= 1'b0;
      r_pop <= '0;
    end else begin
      r_vld <= bus.in_valid;
      if (bus.in_valid) begin
        r_f   <= w_xor;
        r_par <= w_par;
        r_pop <= w_pop;
      end
    end
  end

  assign bus.f        = r_f;
  assign bus.f_valid  = r_vld;
  assign bus.parity   = r_par;
  assign bus.diff_cnt = r_pop;

`ifdef SIMPLE_XOR_MISMATCH_CNT_EN
  logic [CNT_W-1:0] r_mis_cnt;

  // Saturates at all-ones; only reset brings it back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis_cnt <= '0;
    end else if (bus.in_valid && (|w_xor) && (r_mis_cnt != {CNT_W{1'b1}})) begin
      r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

  assign bus.mismatch_cnt = r_mis_cnt;
`endif
endmodule

// File: tb/tb_simple_xor_gate.sv
// Directed bench for simple_xor_gate: WIDTH=1 truth table, WIDTH=8 patterns,
// valid gating, asynchronous reset, and (with the macro) the saturating counter.
module tb_simple_xor_gate;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  simple_xor_gate_if #(.WIDTH(1)) if1 ();
  simple_xor_gate_if #(.WIDTH(8)) if8 ();

  simple_xor_gate #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  simple_xor_gate #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

`ifdef SIMPLE_XOR_MISMATCH_CNT_EN
  simple_xor_gate_if #(.WIDTH(8), .CNT_W(2)) ifc ();
  simple_xor_gate #(.WIDTH(8), .CNT_W(2)) u_cnt (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] f, input logic v,
                      input logic p, input logic [3:0] c);
    check({tag, ".f"},        64'(if8.f),        64'(f));
    check({tag, ".f_valid"},  64'(if8.f_valid),  64'(v));
    check({tag, ".parity"},   64'(if8.parity),   64'(p));
    check({tag, ".diff_cnt"}, 64'(if8.diff_cnt), 64'(c));
  endtask

  // Drive on the falling edge, then look 1 time unit after the rising edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0;
`ifdef SIMPLE_XOR_MISMATCH_CNT_EN
    ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0;
`endif
    #2;
    // Reset state
    chk8("rst8", 8'h00, 1'b0, 1'b0, 4'd0);
    check("rst1.f", 64'(if1.f), 64'd0);
    check("rst1.f_valid", 64'(if1.f_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // WIDTH=1 truth table, back to back
    begin
      logic [1:0] ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic       exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if1.in_valid = 1'b1; if1.a = ab[i][1]; if1.b = ab[i][0];
        cyc();
        check($sformatf("tt%0d.f", i),        64'(if1.f),        64'(exp[i]));
        check($sformatf("tt%0d.f_valid", i),  64'(if1.f_valid),  64'd1);
        check($sformatf("tt%0d.parity", i),   64'(if1.parity),   64'(exp[i]));
        check($sformatf("tt%0d.diff_cnt", i), 64'(if1.diff_cnt), 64'(exp[i]));
      end
      @(negedge clk); if1.in_valid = 1'b0; if1.a = 1'b1; if1.b = 1'b0;
      cyc();
      check("w1_idle.f_valid", 64'(if1.f_valid), 64'd0);
      check("w1_idle.f",       64'(if1.f),       64'd0);
    end

    // WIDTH=8 patterns
    @(negedge clk); if8.in_valid = 1'b1; if8.a = 8'hA5; if8.b = 8'h0F;
    cyc(); chk8("a5x0f", 8'hAA, 1'b1, 1'b0, 4'd4);
    @(negedge clk); if8.a = 8'hFF; if8.b = 8'hFF;
    cyc(); chk8("ffxff", 8'h00, 1'b1, 1'b0, 4'd0);
    @(negedge clk); if8.a = 8'h80; if8.b = 8'h00;
    cyc(); chk8("80x00", 8'h80, 1'b1, 1'b1, 4'd1);
    @(negedge clk); if8.a = 8'h00; if8.b = 8'hFF;
    cyc(); chk8("00xff", 8'hFF, 1'b1, 1'b0, 4'd8);
    @(negedge clk); if8.a = 8'hA5; if8.b = 8'h0F;
    cyc(); chk8("reload", 8'hAA, 1'b1, 1'b0, 4'd4);

    // Valid gating: inputs ignored, including X
    @(negedge clk); if8.in_valid = 1'b0; if8.a = 8'hFF; if8.b = 8'h00;
    cyc(); chk8("hold", 8'hAA, 1'b0, 1'b0, 4'd4);
    @(negedge clk); if8.a = 8'hxx; if8.b = 8'h3x;
    cyc(); chk8("hold_x", 8'hAA, 1'b0, 1'b0, 4'd4);
    @(negedge clk); if8.in_valid = 1'b1; if8.a = 8'h3C; if8.b = 8'h01;
    cyc(); chk8("resume", 8'h3D, 1'b1, 1'b1, 4'd5);

    // Asynchronous reset between edges while f=AA
    @(negedge clk); if8.a = 8'hA5; if8.b = 8'h0F;
    cyc(); chk8("pre_rst", 8'hAA, 1'b1, 1'b0, 4'd4);
    #2 rst_n = 1'b0;
    #1 chk8("async_rst", 8'h00, 1'b0, 1'b0, 4'd0);
    @(negedge clk); rst_n = 1'b1; if8.a = 8'h12; if8.b = 8'h34;
    cyc(); chk8("post_rst", 8'h26, 1'b1, 1'b1, 4'd3);
    @(negedge clk); if8.in_valid = 1'b0;
    cyc(); chk8("post_idle", 8'h26, 1'b0, 1'b1, 4'd3);

`ifdef SIMPLE_XOR_MISMATCH_CNT_EN
    // Counter with CNT_W=2 saturates at 3
    begin
      logic [1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.a = 8'(i + 1);
        ifc.b = (i == 5) ? 8'(i + 1) : 8'h00;
        cyc();
        check($sformatf("mcnt%0d", i), 64'(ifc.mismatch_cnt), 64'(exp_cnt[i]));
      end
      @(negedge clk); ifc.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("mcnt_rst", 64'(ifc.mismatch_cnt), 64'd0);
      @(negedge clk); rst_n = 1'b1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/simple_xor_gate.md
Name: simple_xor_gate

Overview:
Registered bitwise XOR (difference) unit. Compares two operand vectors each valid cycle and presents the XOR result, its parity and its popcount one clock later. Used as a leaf compare/difference block in datapaths. WIDTH=1 reduces it to a clocked 2-input XOR gate.

Parameters:
WIDTH, 1, operand and result width in bits (legal 1..64)
CNT_W, 16, width of optional mismatch counter (legal 1..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b valid this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
f  output  WIDTH  registered a XOR b
f_valid  output  1  f/parity/diff_cnt valid
parity  output  1  XOR-reduction of f
diff_cnt  output  clog2(WIDTH+1) (min 1)  number of set bits in f
mismatch_cnt  output  CNT_W  saturating count of valid cycles with f != 0 (optional feature only)

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous-safe deassert handled by the system): f=0, f_valid=0, parity=0, diff_cnt=0, mismatch_cnt=0. Takes effect immediately without a clock edge.
- Per bit: f[i] = a[i] ^ b[i]. Truth table: 0,0->0; 0,1->1; 1,0->1; 1,1->0.
- Latency: exactly 1 cycle. On a rising clk edge with in_valid=1: f, parity and diff_cnt load from the current a/b, and f_valid=1.
- On a rising edge with in_valid=0: f_valid=0. f, parity and diff_cnt hold their last values.
- parity = ^f at all times. It is registered together with f, so there are no combinational paths from inputs to outputs.
- diff_cnt = popcount(f), range 0..WIDTH, registered together with f.
- No back-pressure: a new operand pair is accepted every cycle in_valid=1. Back-to-back operation is supported.
- Reset asserted mid-stream: all outputs go to 0 immediately. The first valid output after reset is the first pair sampled after rst_n rises.
- a/b values when in_valid=0 are don't-care and must not affect outputs.
- X on a/b while in_valid=0 must not propagate.

Optional Feature:
Macro SIMPLE_XOR_MISMATCH_CNT_EN.
- Defined: mismatch_cnt port exists. It increments by 1 on each rising edge with in_valid=1 and a!=b. It saturates at 2^CNT_W-1 (no wrap), and only reset clears it.
- Not defined: mismatch_cnt port and counter logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=1 truth table: apply a,b = 00,01,10,11 with in_valid=1, one pair per cycle -> f = 0,1,1,0 one cycle later, f_valid=1 each cycle, parity equal to f.
- WIDTH=8 pattern: a=8'hA5, b=8'h0F -> next cycle f=8'hAA, parity=0, diff_cnt=4. Then a=b=8'hFF -> f=0, diff_cnt=0.
- Valid gating: in_valid=0 with a=8'hFF, b=0 -> f_valid=0 and f holds the previous value. Resume with in_valid=1 -> update after 1 cycle.
- Async reset: assert rst_n=0 between clock edges while f=8'hAA -> f, parity, diff_cnt and f_valid are 0 immediately, before the next edge.
- Macro defined, CNT_W=2: 5 valid mismatching pairs plus 1 matching pair -> mismatch_cnt = 1,2,3,3,3, unchanged on the match. Reset clears it to 0.
